// File: rtl/alu_panel_pkg.sv
// ============================================================================
// Module   : alu_panel_pkg
// Brief    : Shared types, segment constants and helpers for the ALU front panel.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_panel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        COMMIT  = 2'd3
    } fsm_e;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_Z = 2'd2
    } ch_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_converter.sv
// ============================================================================
// Module   : bcd_converter
// Brief    : Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_converter #(
    parameter int W      = 6,
    parameter int DIGITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [W-1:0]        mag_i,
    output logic                done_o,
    output logic [4*DIGITS-1:0] bcd_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  bin_q;
    logic [BW-1:0] bcd_q;
    logic [BW-1:0] bcd_adj;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= mag_i;
            bcd_q <= '0;
            cnt_q <= CW'(W);
            run_q <= 1'b1;
        end else if (run_q) begin
            bin_q <= bin_q << 1;
            bcd_q <= BW'({bcd_adj, bin_q[W-1]});
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    // Asserted during the final shift so the result is valid the next cycle.
    assign done_o = run_q && (cnt_q == CW'(1));
    assign bcd_o  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Debounced press sequencer capturing A, B, Z into sign+decimal displays.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer
    import alu_panel_pkg::*;
#(
    parameter int W          = 6,
    parameter int DIGITS     = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic                iclk,
    input  logic                rst,
    input  logic                set,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic [W-1:0]        z,
    input  logic                oFin,
    output logic [7*DIGITS-1:0] aSeg,
    output logic [7*DIGITS-1:0] bSeg,
    output logic [7*DIGITS-1:0] zSeg,
    output logic                aNeg,
    output logic                bNeg,
    output logic                zNeg,
    output logic                oFout,
    output logic [1:0]          stage,
    output logic                busy
);

    localparam int SW = 7 * DIGITS;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DEB_CYCLES + 1);

    if (W < 2 || DEB_CYCLES < 1 || pow10(DIGITS) <= (64'd1 << (W - 1))) begin : g_param_check
        $error("alu_operand_sequencer: illegal W/DIGITS/DEB_CYCLES combination");
    end

    function automatic logic [SW-1:0] seg_of(input logic [BW-1:0] bcd);
        logic [SW-1:0] seg;
`ifdef LEADING_ZERO_BLANK_EN
        logic          lead;
        lead = 1'b1;
`endif
        seg = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            seg[7*d +: 7] = bcd_to_seg(bcd[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && (d != 0) && (bcd[4*d +: 4] == 4'd0)) begin
                seg[7*d +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
            end
`endif
        end
        return seg;
    endfunction

    localparam logic [SW-1:0] c_SEG_RESET = seg_of('0);

    logic [1:0]    sync_q;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press_q, press_d;
    logic          set_low;

    fsm_e          state_q, state_d;
    ch_e           stage_q;
    logic          sign_q, ovf_in_q, busy_q;
    logic [SW-1:0] a_seg_q, b_seg_q, z_seg_q;
    logic          a_neg_q, b_neg_q, z_neg_q, ovf_q;

    logic          conv_start, conv_done;
    logic [BW-1:0] bcd;
    logic [W-1:0]  sel_val, sel_mag;
    logic [SW-1:0] commit_seg;

    assign set_low = ~sync_q[1];

    // Counter saturates at DEB_CYCLES so a held button yields a single pulse.
    always_comb begin
        deb_cnt_d = '0;
        press_d   = 1'b0;
        if (set_low) begin
            deb_cnt_d = (deb_cnt_q == CW'(DEB_CYCLES)) ? deb_cnt_q : deb_cnt_q + CW'(1);
            press_d   = (deb_cnt_q == CW'(DEB_CYCLES - 1));
        end
    end

    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], set};
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE:    if (press_q) state_d = CAPTURE;
            CAPTURE: begin
                conv_start = 1'b1;
                state_d    = CONVERT;
            end
            CONVERT: if (conv_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (stage_q)
            CH_A:    sel_val = a;
            CH_B:    sel_val = b;
            default: sel_val = z;
        endcase
        // -2**(W-1) negates to itself, which reads correctly as an unsigned magnitude.
        sel_mag    = sel_val[W-1] ? (~sel_val + W'(1)) : sel_val;
        commit_seg = seg_of(bcd);
    end

    bcd_converter #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_bcd_converter (
        .clk_i   (iclk),
        .rst_ni  (rst),
        .start_i (conv_start),
        .mag_i   (sel_mag),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_ff @(posedge iclk or negedge rst) begin
        if (!rst) begin
            stage_q  <= CH_A;
            sign_q   <= 1'b0;
            ovf_in_q <= 1'b0;
            busy_q   <= 1'b0;
            a_seg_q  <= c_SEG_RESET;
            b_seg_q  <= c_SEG_RESET;
            z_seg_q  <= c_SEG_RESET;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            z_neg_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == CAPTURE) begin
                sign_q   <= sel_val[W-1];
                ovf_in_q <= oFin;
                busy_q   <= 1'b1;
            end
            if (state_q == COMMIT) begin
                busy_q <= 1'b0;
                case (stage_q)
                    CH_A: begin
                        a_seg_q <= commit_seg;
                        a_neg_q <= sign_q;
                        stage_q <= CH_B;
                    end
                    CH_B: begin
                        b_seg_q <= commit_seg;
                        b_neg_q <= sign_q;
                        stage_q <= CH_Z;
                    end
                    CH_Z: begin
                        z_seg_q <= commit_seg;
                        z_neg_q <= sign_q;
                        ovf_q   <= ovf_in_q;
                        stage_q <= CH_A;
                    end
                    default: stage_q <= CH_A;
                endcase
            end
        end
    end

    assign aSeg  = a_seg_q;
    assign bSeg  = b_seg_q;
    assign zSeg  = z_seg_q;
    assign aNeg  = a_neg_q;
    assign bNeg  = b_neg_q;
    assign zNeg  = z_neg_q;
    assign oFout = ovf_q;
    assign stage = stage_q;
    assign busy  = busy_q;

endmodule

`default_nettype wire
